regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; next generation of the core's 2-read/1-write register file.
- Generalised in data width, register count and read-port count. Optional same-cycle write-to-read bypass. Optional registered read outputs.
- Adds a hardware clear sequencer that zeroes the array after reset, since the storage array has no reset.
- Sits between decode (read addresses) and writeback (write port) in the RISC-V datapath.

Parameters:
XLEN, 32, data width in bits
DEPTH, 32, number of registers (power of two, >= 2)
AW, 5, address width, must equal log2(DEPTH)
NR_READ, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes
BYPASS, 1, 1 = a read of the address being written returns di (write-first)
READ_REG, 0, 0 = combinational read; 1 = read data registered, 1-cycle latency

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
we  input  1  write enable
rd  input  AW  write address
di  input  XLEN  write data
raddr  input  NR_READ*AW  read addresses, port p at bits [p*AW +: AW]
rdata  output  NR_READ*XLEN  read data, port p at bits [p*XLEN +: XLEN]
busy  output  1  clear sweep in progress; writes dropped, reads return 0

Behaviour:
- Reset: clk and rst are as decided — one clock; rst is synchronous and active-high.
  - While rst=1: state=CLEAR, sweep counter=0, busy=1.
  - If READ_REG=1, all rdata registers read 0.
  - Array contents are not guaranteed until the sweep completes.
- FSM states: CLEAR, RUN.
  - CLEAR: each cycle with rst=0, write 0 to array[cnt], then cnt+1.
  - When cnt=DEPTH-1 has been written, the next state is RUN. busy=0 from the following cycle.
  - Total: busy is high for exactly DEPTH cycles after rst falls.
  - rst asserted mid-sweep: cnt returns to 0 and the sweep restarts from the beginning after release.
  - RUN: stays in RUN until rst.
- Writes (RUN only):
  - On a rising edge with we=1, array[rd] <= di.
  - ZERO_REG=1 and rd=0: write dropped.
  - we while busy=1: dropped silently; not queued.
- Reads:
  - Each port is independent. Any number of ports may read the same address.
  - Base value is array[raddr_p].
  - Forced to 0 if busy=1, or if ZERO_REG=1 and raddr_p=0.
  - Bypass (BYPASS=1, RUN, we=1, rd=raddr_p, and not the zero register): value = di.
  - BYPASS=0: the read returns the old contents in the write cycle and the new contents from the next cycle.
- Read timing:
  - READ_REG=0: rdata is combinational from raddr in the same cycle.
  - READ_REG=1: rdata is captured at the rising edge from the value above, so it appears one cycle after raddr. Bypass still compares against the same-cycle we/rd/di.
- Width rules:
  - Address compare uses all AW bits; there is no wrap-around beyond DEPTH.
  - The sweep counter is AW+1 bits so the terminal count is detected without aliasing.
- No X on rdata after the sweep completes. Bench checks rdata only when busy=0.

Decomposition:
- Shared include (regfile_defs): FSM state encodings (ST_CLEAR=1'b0, ST_RUN=1'b1) and a localparam helper for the AW consistency check. Parameter mismatch triggers a simulation $error.
- One sub-module: regfile_read_port. Holds the zero-force, bypass mux and optional output register. It is instantiated NR_READ times in a generate loop.
- The storage array and clear FSM stay in the top module.

Test Plan:
- Clear sweep:
  - Stimulus: rst high 3 cycles, then low; DEPTH=32.
  - Required: busy=1 for exactly 32 cycles, then 0. Every address reads 0x00000000 on all ports.
  - During busy, we=1 rd=5 di=0xDEADBEEF is dropped; register 5 reads 0 afterwards.
- Basic write/read:
  - Stimulus: write rd=7 di=0x12345678.
  - Required: next cycle raddr0=7 and raddr1=7 both return 0x12345678.
  - Write rd=0 di=0xFFFFFFFF leaves register 0 reading 0.
- Bypass:
  - Stimulus: BYPASS=1, READ_REG=0, same-cycle we=1 rd=3 di=0xA5A5A5A5 with raddr1=3.
  - Required: rdata1=0xA5A5A5A5 in that cycle.
  - With BYPASS=0: rdata1 shows the previous value (0x0), then 0xA5A5A5A5 next cycle.
- Registered read:
  - Stimulus: READ_REG=1, NR_READ=3; ports read addresses 1,2,1 holding 0x11,0x22,0x11.
  - Required: values appear exactly one cycle after the addresses are applied.
- Reset mid-sweep:
  - Stimulus: rst pulsed for 1 cycle at sweep cycle 10.
  - Required: busy stays high for a further 32 cycles after release; no stale data visible.
- Parameter sweep:
  - Stimulus: XLEN=64, DEPTH=16, AW=4; random traffic of 1000 writes/reads against a reference model.
  - Required: zero mismatches; rd=15 (top) and rd=0 behave per ZERO_REG.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: clear-sequencer state
// encodings and the elaboration-time parameter consistency check.
package regfile_mp_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // DEPTH must be a power of two (>= 2) addressed by exactly AW bits.
  function automatic bit aw_ok(int depth, int aw);
    return (depth >= 2) && ((1 << aw) == depth);
  endfunction

endpackage

// File: rtl/regfile_mp_read_port.sv
// One read port: zero-force, write-first bypass and optional output register.
module regfile_mp_read_port
  import regfile_mp_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int READ_REG = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            busy,
  input  logic            we,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] di,
  input  logic [AW-1:0]   raddr,
  input  logic [XLEN-1:0] arr_data,
  output logic [XLEN-1:0] rdata
);

  logic            is_zero;
  logic [XLEN-1:0] val;
  logic [XLEN-1:0] rdata_q;

  assign is_zero = (ZERO_REG != 0) && (raddr == '0);

  // busy takes priority, so the bypass can only fire while the array is live
  always_comb begin
    val = arr_data;
    if (busy || is_zero) begin
      val = '0;
    end else if ((BYPASS != 0) && we && (rd == raddr)) begin
      val = di;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= val;
    end
  end

  assign rdata = (READ_REG != 0) ? rdata_q : val;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with a post-reset clear sequencer.
// state    | meaning
// ST_CLEAR | sweeping zeros into array[cnt]; writes dropped, reads return 0
// ST_RUN   | normal operation until the next reset
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int NR_READ  = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int READ_REG = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [AW-1:0]           rd,
  input  logic [XLEN-1:0]         di,
  input  logic [NR_READ*AW-1:0]   raddr,
  output logic [NR_READ*XLEN-1:0] rdata,
  output logic                    busy
);

  if (!aw_ok(DEPTH, AW)) begin : g_param_check
    $error("regfile_mp: DEPTH=%0d is not 2**AW (AW=%0d)", DEPTH, AW);
  end

  // Counter is one bit wider than the address so the last index never aliases.
  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);

  state_t          state;
  logic [AW:0]     cnt;
  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else if (state == ST_CLEAR) begin
      cnt <= cnt + 1'b1;
      if (cnt == CNT_LAST) begin
        state <= ST_RUN;
      end
    end
  end

  // Storage has no reset; the sweep above is what establishes known contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_CLEAR) begin
        mem[cnt[AW-1:0]] <= '0;
      end else if (we && !((ZERO_REG != 0) && (rd == '0))) begin
        mem[rd] <= di;
      end
    end
  end

  assign busy = (state == ST_CLEAR);

  for (genvar p = 0; p < NR_READ; p++) begin : g_rp
    regfile_mp_read_port #(
      .XLEN     (XLEN),
      .AW       (AW),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS),
      .READ_REG (READ_REG)
    ) u_rp (
      .clk      (clk),
      .rst      (rst),
      .busy     (busy),
      .we       (we),
      .rd       (rd),
      .di       (di),
      .raddr    (raddr[p*AW +: AW]),
      .arr_data (mem[raddr[p*AW +: AW]]),
      .rdata    (rdata[p*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp across four parameter sets sharing one clock/reset.
module tb_regfile_mp;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         we  = 1'b0;
  logic [4:0]   rd  = '0;
  logic [31:0]  di  = '0;
  logic [9:0]   raddr_ab = '0;
  logic [14:0]  raddr_c  = '0;
  logic [63:0]  rdata_a, rdata_b;
  logic [95:0]  rdata_c;
  logic         busy_a, busy_b, busy_c;

  logic         we_d = 1'b0;
  logic [3:0]   rd_d = '0;
  logic [63:0]  di_d = '0;
  logic [7:0]   raddr_d = '0;
  logic [127:0] rdata_d;
  logic         busy_d;

  int checks = 0;
  int errors = 0;
  logic [63:0] mdl [16];

  always #5 clk = ~clk;

  regfile_mp u_a (
    .clk(clk), .rst(rst), .we(we), .rd(rd), .di(di),
    .raddr(raddr_ab), .rdata(rdata_a), .busy(busy_a)
  );

  regfile_mp #(.BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .we(we), .rd(rd), .di(di),
    .raddr(raddr_ab), .rdata(rdata_b), .busy(busy_b)
  );

  regfile_mp #(.NR_READ(3), .READ_REG(1)) u_c (
    .clk(clk), .rst(rst), .we(we), .rd(rd), .di(di),
    .raddr(raddr_c), .rdata(rdata_c), .busy(busy_c)
  );

  regfile_mp #(.XLEN(64), .DEPTH(16), .AW(4)) u_d (
    .clk(clk), .rst(rst), .we(we_d), .rd(rd_d), .di(di_d),
    .raddr(raddr_d), .rdata(rdata_d), .busy(busy_d)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0]  a4;
    logic [63:0] exp;

    // reset for three edges, then watch the sweep while a write is attempted
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 64'(busy_a), 64'd1);
    chk("rst_rdata_c", rdata_c[63:0], 64'd0);
    rst = 1'b0;
    we = 1'b1; rd = 5'd5; di = 32'hDEADBEEF;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("sweep_busy_a", 64'(busy_a), 64'd1);
      chk("sweep_busy_d", 64'(busy_d), (i < 16) ? 64'd1 : 64'd0);
      chk("sweep_rdata_a", rdata_a, 64'd0);
      @(negedge clk);
    end
    we = 1'b0;
    #1;
    chk("sweep_done_a", 64'(busy_a), 64'd0);
    chk("sweep_done_b", 64'(busy_b), 64'd0);
    chk("sweep_done_c", 64'(busy_c), 64'd0);

    // every address reads zero on every port (register 5 write was dropped)
    for (int adr = 0; adr < 32; adr++) begin
      raddr_ab = {5'(adr), 5'(adr)};
      raddr_c  = {5'(adr), 5'(adr), 5'(adr)};
      @(negedge clk);
      #1;
      chk("clear_a", rdata_a, 64'd0);
      chk("clear_b", rdata_b, 64'd0);
      chk("clear_c", rdata_c[63:0], 64'd0);
      chk("clear_c2", 64'(rdata_c[95:64]), 64'd0);
    end

    // basic write then read on both ports
    @(negedge clk);
    we = 1'b1; rd = 5'd7; di = 32'h12345678;
    @(negedge clk);
    we = 1'b0; raddr_ab = {5'd7, 5'd7};
    #1;
    chk("wr7_a", rdata_a, 64'h12345678_12345678);
    chk("wr7_b", rdata_b, 64'h12345678_12345678);

    // same-cycle write/read of register 3: bypass vs write-then-read
    @(negedge clk);
    we = 1'b1; rd = 5'd3; di = 32'hA5A5A5A5; raddr_ab = {5'd3, 5'd7};
    #1;
    chk("byp_a_p1", 64'(rdata_a[63:32]), 64'hA5A5A5A5);
    chk("byp_a_p0", 64'(rdata_a[31:0]), 64'h12345678);
    chk("nobyp_b_p1_old", 64'(rdata_b[63:32]), 64'h0);
    @(negedge clk);
    we = 1'b0;
    #1;
    chk("nobyp_b_p1_new", 64'(rdata_b[63:32]), 64'hA5A5A5A5);
    chk("byp_a_p1_held", 64'(rdata_a[63:32]), 64'hA5A5A5A5);

    // register 0: bypass suppressed, write dropped
    @(negedge clk);
    we = 1'b1; rd = 5'd0; di = 32'hFFFFFFFF; raddr_ab = {5'd0, 5'd0};
    #1;
    chk("zero_byp_a", rdata_a, 64'd0);
    @(negedge clk);
    we = 1'b0;
    #1;
    chk("zero_wr_a", rdata_a, 64'd0);
    chk("zero_wr_b", rdata_b, 64'd0);

    // registered read: 1-cycle latency
    @(negedge clk);
    raddr_c = {5'd31, 5'd31, 5'd31};
    we = 1'b1; rd = 5'd1; di = 32'h11;
    @(negedge clk);
    rd = 5'd2; di = 32'h22;
    @(negedge clk);
    we = 1'b0; raddr_c = {5'd1, 5'd2, 5'd1};
    #1;
    chk("rreg_lat_p0", 64'(rdata_c[31:0]), 64'h0);
    chk("rreg_lat_p1", 64'(rdata_c[63:32]), 64'h0);
    @(negedge clk);
    #1;
    chk("rreg_p0", 64'(rdata_c[31:0]), 64'h11);
    chk("rreg_p1", 64'(rdata_c[63:32]), 64'h22);
    chk("rreg_p2", 64'(rdata_c[95:64]), 64'h11);

    // registered bypass captures di, not the old array value
    @(negedge clk);
    we = 1'b1; rd = 5'd4; di = 32'h44; raddr_c = {5'd4, 5'd4, 5'd4};
    @(negedge clk);
    we = 1'b0;
    #1;
    chk("rreg_byp_p0", 64'(rdata_c[31:0]), 64'h44);

    // reset, then a second reset pulse at sweep cycle 10
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("mid_busy_before", 64'(busy_a), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    raddr_ab = {5'd3, 5'd7};
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("mid_busy_a", 64'(busy_a), 64'd1);
      chk("mid_busy_d", 64'(busy_d), (i < 16) ? 64'd1 : 64'd0);
      chk("mid_rdata_a", rdata_a, 64'd0);
      @(negedge clk);
    end
    #1;
    chk("mid_done_a", 64'(busy_a), 64'd0);
    chk("mid_stale_a", rdata_a, 64'd0);
    chk("mid_stale_b", rdata_b, 64'd0);

    // 64-bit x 16 instance: top and zero register directed, then random traffic
    for (int k = 0; k < 16; k++) mdl[k] = '0;
    @(negedge clk);
    we_d = 1'b1; rd_d = 4'd15; di_d = 64'hFEDCBA98_76543210;
    @(negedge clk);
    rd_d = 4'd0; di_d = 64'hFFFFFFFF_FFFFFFFF; raddr_d = {4'd0, 4'd15};
    #1;
    chk("d_top", rdata_d[63:0], 64'hFEDCBA98_76543210);
    chk("d_zero_byp", rdata_d[127:64], 64'd0);
    @(negedge clk);
    we_d = 1'b0;
    #1;
    chk("d_zero_wr", rdata_d[127:64], 64'd0);
    mdl[15] = 64'hFEDCBA98_76543210;

    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      we_d = 1'($urandom_range(0, 1));
      rd_d = 4'($urandom_range(0, 15));
      di_d = {$urandom, $urandom};
      raddr_d[3:0] = 4'($urandom_range(0, 15));
      raddr_d[7:4] = ($urandom_range(0, 3) == 0) ? rd_d : 4'($urandom_range(0, 15));
      #1;
      for (int p = 0; p < 2; p++) begin
        a4 = raddr_d[p*4 +: 4];
        if (a4 == 4'd0)                    exp = '0;
        else if (we_d && (rd_d == a4))     exp = di_d;
        else                               exp = mdl[a4];
        chk("d_rand", rdata_d[p*64 +: 64], exp);
      end
      if (we_d && (rd_d != 4'd0)) mdl[rd_d] = di_d;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
